// File: rtl/uart_pkg.sv
// Package: uart_pkg
// Purpose: shared UART definitions used by the transmitter, receiver and the
//          receive-side FIFO.
// Contents:
//   UART_DATA_W  - width of one UART character
//   uart_byte_t  - one UART character
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Module: uart_sync_fifo
// Purpose: single-clock show-ahead FIFO with an explicit occupancy counter,
//          so full and empty can never be confused when the pointers meet.
// Ports:
//   i_clk      - system clock, rising edge
//   i_rst      - synchronous active-high reset
//   i_push     - write request; honoured when not full, or full with a pop
//   i_pop      - read request; ignored while empty
//   i_wr_data  - byte to write
//   o_rd_data  - head entry (zero while empty)
//   o_full     - count == DEPTH
//   o_empty    - count == 0
//   o_count    - stored entries, 0..DEPTH
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic              w_doPush;
  logic              w_doPop;

  // A pop frees a slot in the same cycle, so a push against a full FIFO is
  // still accepted when it is paired with a pop.
  always_comb begin
    w_doPop  = i_pop & ~o_empty;
    w_doPush = i_push & (~o_full | w_doPop);
  end

  // Storage holds no reset; only the pointers and count decide what is valid.
  always_ff @(posedge i_clk) begin
    if (w_doPush && !i_rst) begin
      r_mem[r_wrPtr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry is shown directly from storage; it reads as zero while empty
  // so stale bytes never leak onto the output.
  always_comb begin
    o_empty   = (r_count == '0);
    o_full    = (r_count == CNT_FULL);
    o_count   = r_count;
    o_rd_data = o_empty ? '0 : r_mem[r_rdPtr];
  end

endmodule : uart_sync_fifo

// File: rtl/uart_rx_fifo.sv
// Module: uart_rx_fifo
// Purpose: receive-side byte buffer behind the UART receiver. Each rising
//          edge of the receiver's done strobe pushes one byte into a
//          show-ahead FIFO; the consumer drains it over valid/ready. Bytes
//          arriving while full (with no simultaneous pop) are dropped and
//          flagged in a sticky overflow bit.
// Configuration macro: UART_RX_FIFO_STATS_EN adds o_drop_cnt, a saturating
//          16-bit dropped-byte counter cleared by i_clr_ovf.
// Ports:
//   i_clk       - system clock, rising edge
//   i_rst       - synchronous active-high reset
//   i_rx_data   - byte from the receiver
//   i_rx_done   - receiver done (level or pulse)
//   o_rd_data   - head-of-queue byte, valid while o_rd_valid
//   o_rd_valid  - FIFO not empty
//   i_rd_ready  - consumer accepts the head byte
//   o_count     - stored bytes, 0..DEPTH
//   o_full      - FIFO full
//   o_overflow  - sticky drop flag
//   i_clr_ovf   - clears o_overflow (and o_drop_cnt)
//   o_drop_cnt  - dropped-byte count (only with UART_RX_FIFO_STATS_EN)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_done,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_overflow,
  input  logic              i_clr_ovf
`ifdef UART_RX_FIFO_STATS_EN
  ,output logic [15:0]      o_drop_cnt
`endif
);

  logic r_doneQ;
  logic r_overflow;
  logic w_pushReq;
  logic w_pop;
  logic w_drop;
  logic w_empty;

  // The done register keeps following rx_done even during reset, so a done
  // level that is still high when reset releases is not mistaken for a new
  // byte.
  always_ff @(posedge i_clk) begin
    r_doneQ <= i_rx_done;
  end

  // One push per rising edge of done; a drop is a push the FIFO cannot take
  // because it is full and nothing is leaving in the same cycle.
  always_comb begin
    w_pushReq = i_rx_done & ~r_doneQ;
    w_pop     = o_rd_valid & i_rd_ready;
    w_drop    = w_pushReq & o_full & ~w_pop;
  end

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (w_pushReq),
    .i_pop     (w_pop),
    .i_wr_data (i_rx_data),
    .o_rd_data (o_rd_data),
    .o_full    (o_full),
    .o_empty   (w_empty),
    .o_count   (o_count)
  );

  assign o_rd_valid = ~w_empty;

  // Sticky overflow; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_overflow = r_overflow;

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] r_dropCnt;

  // Saturating drop counter; a clear coinciding with a drop restarts at one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dropCnt <= '0;
    end else if (i_clr_ovf) begin
      r_dropCnt <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_dropCnt != 16'hFFFF)) begin
      r_dropCnt <= r_dropCnt + 16'd1;
    end
  end

  assign o_drop_cnt = r_dropCnt;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Testbench: tb_uart_rx_fifo
// Purpose: directed self-checking bench for uart_rx_fifo (DEPTH=16, 8-bit).
//          Inputs change 1 ns after each rising edge and outputs are sampled
//          in that same settled window.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxData;
  logic       rxDone;
  logic [7:0] rdData;
  logic       rdValid;
  logic       rdReady;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       clrOvf;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] dropCnt;
`endif

  int nChecks = 0;
  int nFails  = 0;

  uart_rx_fifo dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rxData),
    .i_rx_done  (rxDone),
    .o_rd_data  (rdData),
    .o_rd_valid (rdValid),
    .i_rd_ready (rdReady),
    .o_count    (count),
    .o_full     (full),
    .o_overflow (overflow),
    .i_clr_ovf  (clrOvf)
`ifdef UART_RX_FIFO_STATS_EN
    ,.o_drop_cnt (dropCnt)
`endif
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle done pulse followed by one idle cycle.
  task automatic applyStimulus(input logic [7:0] b);
    rxData = b;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    tick();
  endtask

  // Reset with done low; every output must come up cleared.
  task automatic test_reset();
    rst = 1'b1; rxData = '0; rxDone = 1'b0; rdReady = 1'b0; clrOvf = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    nChecks++; if (rdValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b expected 0", rdValid); end
    nChecks++; if (count !== 5'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    nChecks++; if (full !== 1'b0) begin nFails++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    nChecks++; if (rdData !== 8'h00) begin nFails++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rdData); end
`ifdef UART_RX_FIFO_STATS_EN
    nChecks++; if (dropCnt !== 16'd0) begin nFails++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", dropCnt); end
`endif
  endtask

  // Three pulses, consumer idle.
  task automatic test_capture();
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    applyStimulus(8'hFF);
    nChecks++; if (count !== 5'd3) begin nFails++; $display("[TB] FAIL capture_count: got %0d expected 3", count); end
    nChecks++; if (rdData !== 8'hA5) begin nFails++; $display("[TB] FAIL capture_head: got %h expected a5", rdData); end
    nChecks++; if (rdValid !== 1'b1) begin nFails++; $display("[TB] FAIL capture_valid: got %b expected 1", rdValid); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL capture_overflow: got %b expected 0", overflow); end
  endtask

  // Done held for five cycles pushes once; then drain everything in order.
  task automatic test_held_done();
    logic [7:0] expOrder [4];
    expOrder[0] = 8'hA5; expOrder[1] = 8'h3C; expOrder[2] = 8'hFF; expOrder[3] = 8'h42;
    rxData = 8'h42;
    rxDone = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rxDone = 1'b0;
    tick();
    nChecks++; if (count !== 5'd4) begin nFails++; $display("[TB] FAIL held_count: got %0d expected 4", count); end
    for (int i = 0; i < 4; i++) begin
      nChecks++; if (rdData !== expOrder[i]) begin nFails++; $display("[TB] FAIL held_drain[%0d]: got %h expected %h", i, rdData, expOrder[i]); end
      rdReady = 1'b1; tick(); rdReady = 1'b0;
    end
    nChecks++; if (rdValid !== 1'b0 || count !== 5'd0) begin nFails++; $display("[TB] FAIL held_empty: got valid=%b count=%0d expected valid=0 count=0", rdValid, count); end
  endtask

  // Fill to 16, drop one byte, then exercise clear and clear-with-drop.
  task automatic test_overflow();
    for (int i = 0; i < 16; i++) applyStimulus(8'h10 + 8'(i));
    nChecks++; if (full !== 1'b1 || count !== 5'd16) begin nFails++; $display("[TB] FAIL fill_full: got full=%b count=%0d expected full=1 count=16", full, count); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL fill_overflow: got %b expected 0", overflow); end
    applyStimulus(8'h99);
    nChecks++; if (overflow !== 1'b1) begin nFails++; $display("[TB] FAIL drop_overflow: got %b expected 1", overflow); end
    nChecks++; if (count !== 5'd16 || full !== 1'b1) begin nFails++; $display("[TB] FAIL drop_count: got count=%0d full=%b expected count=16 full=1", count, full); end
    nChecks++; if (rdData !== 8'h10) begin nFails++; $display("[TB] FAIL drop_head: got %h expected 10", rdData); end
`ifdef UART_RX_FIFO_STATS_EN
    nChecks++; if (dropCnt !== 16'd1) begin nFails++; $display("[TB] FAIL drop_cnt_one: got %0d expected 1", dropCnt); end
`endif
    clrOvf = 1'b1; tick(); clrOvf = 1'b0;
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL clear_overflow: got %b expected 0", overflow); end
`ifdef UART_RX_FIFO_STATS_EN
    nChecks++; if (dropCnt !== 16'd0) begin nFails++; $display("[TB] FAIL clear_drop_cnt: got %0d expected 0", dropCnt); end
    applyStimulus(8'h98); applyStimulus(8'h97);
    nChecks++; if (dropCnt !== 16'd2) begin nFails++; $display("[TB] FAIL drop_cnt_two: got %0d expected 2", dropCnt); end
`endif
    rxData = 8'h9A; rxDone = 1'b1; clrOvf = 1'b1;
    tick();
    rxDone = 1'b0; clrOvf = 1'b0;
    nChecks++; if (overflow !== 1'b1) begin nFails++; $display("[TB] FAIL clr_drop_overflow: got %b expected 1", overflow); end
`ifdef UART_RX_FIFO_STATS_EN
    nChecks++; if (dropCnt !== 16'd1) begin nFails++; $display("[TB] FAIL clr_drop_cnt: got %0d expected 1", dropCnt); end
`endif
    tick();
    clrOvf = 1'b1; tick(); clrOvf = 1'b0;
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL reclear_overflow: got %b expected 0", overflow); end
  endtask

  // Full FIFO: push and pop together, then verify the whole drain order.
  task automatic test_push_pop_full();
    logic [7:0] expByte;
    rxData = 8'h77; rxDone = 1'b1; rdReady = 1'b1;
    tick();
    rxDone = 1'b0; rdReady = 1'b0;
    nChecks++; if (count !== 5'd16) begin nFails++; $display("[TB] FAIL pp_count: got %0d expected 16", count); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL pp_overflow: got %b expected 0", overflow); end
    nChecks++; if (rdData !== 8'h11) begin nFails++; $display("[TB] FAIL pp_head: got %h expected 11", rdData); end
    tick();
    for (int i = 0; i < 16; i++) begin
      expByte = (i < 15) ? (8'h11 + 8'(i)) : 8'h77;
      nChecks++; if (rdData !== expByte || rdValid !== 1'b1) begin nFails++; $display("[TB] FAIL pp_drain[%0d]: got %h valid=%b expected %h valid=1", i, rdData, rdValid, expByte); end
      rdReady = 1'b1; tick(); rdReady = 1'b0;
    end
    nChecks++; if (rdValid !== 1'b0 || count !== 5'd0) begin nFails++; $display("[TB] FAIL pp_empty: got valid=%b count=%0d expected valid=0 count=0", rdValid, count); end
  endtask

  // Empty FIFO with consumer always ready: one-cycle visibility, then gone.
  task automatic test_back_to_back();
    rdReady = 1'b1;
    tick();
    nChecks++; if (count !== 5'd0 || rdValid !== 1'b0) begin nFails++; $display("[TB] FAIL idle_ready: got count=%0d valid=%b expected count=0 valid=0", count, rdValid); end
    rxData = 8'h11; rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    nChecks++; if (rdValid !== 1'b1 || rdData !== 8'h11) begin nFails++; $display("[TB] FAIL latency_visible: got valid=%b data=%h expected valid=1 data=11", rdValid, rdData); end
    nChecks++; if (count !== 5'd1) begin nFails++; $display("[TB] FAIL latency_count: got %0d expected 1", count); end
    tick();
    nChecks++; if (rdValid !== 1'b0 || count !== 5'd0) begin nFails++; $display("[TB] FAIL latency_popped: got valid=%b count=%0d expected valid=0 count=0", rdValid, count); end
    rdReady = 1'b0;
  endtask

  // Reset mid-stream with done high: queue flushed, no phantom push after.
  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) applyStimulus(8'hC0 + 8'(i));
    nChecks++; if (count !== 5'd5) begin nFails++; $display("[TB] FAIL mid_prefill: got %0d expected 5", count); end
    rxData = 8'h55; rxDone = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    nChecks++; if (count !== 5'd0 || rdValid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_reset: got count=%0d valid=%b expected count=0 valid=0", count, rdValid); end
    tick();
    nChecks++; if (count !== 5'd0 || rdValid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_no_push: got count=%0d valid=%b expected count=0 valid=0", count, rdValid); end
    rxDone = 1'b0;
    tick();
    applyStimulus(8'h5A);
    nChecks++; if (count !== 5'd1 || rdData !== 8'h5A) begin nFails++; $display("[TB] FAIL mid_recover: got count=%0d data=%h expected count=1 data=5a", count, rdData); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_held_done();
    test_overflow();
    test_push_pop_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_uart_rx_fifo
